// File: rtl/led_arb_pkg.sv
// Purpose : shared constants and state encoding for the LED bank arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state type, dwell constants for 100 MHz hardware and for simulation.
package led_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // 0.5 s at 100 MHz.
    localparam int DWELL_100MHZ = 50_000_000;

    // Short dwell so simulations rotate quickly.
    localparam int DWELL_SIM = 4;

endpackage

// File: rtl/rr_pick.sv
// Purpose : combinational round-robin pick; first set request searching cyclically from i_ptr.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; o_vld low when no request is set.
// Ports   : i_req[N_REQ] requests, i_ptr search start, o_idx winner index, o_vld winner exists.
module rr_pick
    import led_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [PW-1:0]    o_idx,
    output logic             o_vld
);

    logic [2*N_REQ-1:0] w_req2;
    logic [N_REQ-1:0]   w_rot;
    logic [PW-1:0]      w_off;
    logic               w_any;
    logic [PW:0]        w_sum;

    // Rotate so that bit 0 of w_rot corresponds to requester i_ptr.
    assign w_req2 = {i_req, i_req};
    assign w_rot  = N_REQ'(w_req2 >> i_ptr);

    // Lowest set offset wins; iterate downward so the smallest offset is written last.
    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_off = PW'(k);
            end
        end
    end

    // Map the offset back to an absolute index, modulo N_REQ.
    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx = (w_sum >= (PW+1)'(N_REQ)) ? PW'(w_sum - (PW+1)'(N_REQ)) : w_sum[PW-1:0];
    assign o_vld = w_any;

endmodule

// File: rtl/led_bank_arbiter.sv
// Purpose : round-robin share of the LED bank among N_REQ demo units, fixed dwell per grant.
// Latency : 1 cycle req->grant/led; 1 cycle data->led while holding.
// Backpressure: none; holder keeps the bank until dwell expiry or it drops req, others wait.
// Ports   : clk, rst (sync, active-high), req[N_REQ], data[N_REQ*W] -> led[W], grant[N_REQ], busy.
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 16,
    parameter int DWELL = DWELL_100MHZ
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] data,
    output logic [W-1:0]       led,
    output logic [N_REQ-1:0]   grant,
    output logic               busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (DWELL > 1) ? $clog2(DWELL + 1) : 1;

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [PW-1:0]    r_cur;
    logic [PW-1:0]    r_ptr;
    logic [W-1:0]     r_led;
    logic [N_REQ-1:0] r_grant;
    logic             r_busy;

    logic [W-1:0]     w_data [N_REQ];
    logic [PW-1:0]    w_win;
    logic             w_win_vld;
    logic             w_event;

    for (genvar g = 0; g < N_REQ; g++) begin : g_data
        assign w_data[g] = data[g*W +: W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_idx (w_win),
        .o_vld (w_win_vld)
    );

    // Arbitrate when idle with any request, or when holding and the dwell expires or the holder leaves.
    assign w_event = (r_state == ST_IDLE) ? (|req)
                   : ((r_timer == TW'(DWELL - 1)) || !req[r_cur]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_cur   <= '0;
            r_ptr   <= '0;
            r_led   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
        end else if (w_event) begin
            r_timer <= '0;
            if (w_win_vld) begin
                r_state <= ST_HOLD;
                r_cur   <= w_win;
                r_ptr   <= (w_win == PW'(N_REQ - 1)) ? '0 : w_win + PW'(1);
                r_grant <= N_REQ'(1) << w_win;
                r_led   <= w_data[w_win];
                r_busy  <= 1'b1;
            end else begin
                // Pointer is left alone so rotation resumes after the last holder.
                r_state <= ST_IDLE;
                r_grant <= '0;
                r_led   <= '0;
                r_busy  <= 1'b0;
            end
        end else if (r_state == ST_HOLD) begin
            r_timer <= r_timer + TW'(1);
            r_led   <= w_data[r_cur];
        end
    end

    assign led   = r_led;
    assign grant = r_grant;
    assign busy  = r_busy;

endmodule

// File: tb/tb_led_bank_arbiter.sv
module tb_led_bank_arbiter;
    import led_arb_pkg::*;

    localparam int N_REQ = 4;
    localparam int W     = 16;

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] data;
    logic [W-1:0]       led;
    logic [N_REQ-1:0]   grant;
    logic               busy;

    int checks;
    int errors;

    led_bank_arbiter #(
        .N_REQ (N_REQ),
        .W     (W),
        .DWELL (DWELL_SIM)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data  (data),
        .led   (led),
        .grant (grant),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [15:0] el, input logic eb);
        chk({tag, ".grant"}, {28'd0, grant}, {28'd0, eg});
        chk({tag, ".led"},   {16'd0, led},   {16'd0, el});
        chk({tag, ".busy"},  {31'd0, busy},  {31'd0, eb});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        req  = '0;
        data = '0;
        tick();
        tick();
        chk_out("reset", 4'b0000, 16'h0000, 1'b0);

        // Idle with no requests.
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk_out("idle", 4'b0000, 16'h0000, 1'b0);
        end

        // Single requester: grant after one edge, re-granted at expiry with no gap.
        data[0 +: 16] = 16'hA5A5;
        req = 4'b0001;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk_out("solo", 4'b0001, 16'hA5A5, 1'b1);
        end

        // Holder drops with nobody else pending -> idle.
        req = 4'b0000;
        tick();
        chk_out("release_idle", 4'b0000, 16'h0000, 1'b0);

        // Reset so rotation starts from requester 0.
        rst = 1'b1;
        tick();
        chk_out("reset2", 4'b0000, 16'h0000, 1'b0);
        rst = 1'b0;

        // Full rotation, 4 cycles per holder.
        data = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
        req  = 4'b1111;
        for (int n = 1; n <= 16; n++) begin
            tick();
            chk_out("rotate", 4'(1 << ((n - 1) / 4)), 16'(1 << ((n - 1) / 4)), 1'b1);
        end
        tick();
        chk_out("wrap", 4'b0001, 16'h0001, 1'b1);

        // Holder 0 drops at dwell cycle 1, requester 2 pending -> direct switch.
        tick();
        chk_out("dwell1", 4'b0001, 16'h0001, 1'b1);
        req = 4'b0100;
        tick();
        chk_out("drop_switch", 4'b0100, 16'h0004, 1'b1);

        // Live data tracking for the holder.
        rst = 1'b1;
        tick();
        chk_out("reset3", 4'b0000, 16'h0000, 1'b0);
        rst = 1'b0;
        data[0 +: 16] = 16'h00FF;
        req = 4'b0001;
        tick();
        chk_out("track0", 4'b0001, 16'h00FF, 1'b1);
        data[0 +: 16] = 16'hFF00;
        tick();
        chk_out("track1", 4'b0001, 16'hFF00, 1'b1);

        // Reset mid-dwell, then first grant goes to requester 0.
        req = 4'b1111;
        tick();
        chk_out("pre_rst", 4'b0001, 16'hFF00, 1'b1);
        rst = 1'b1;
        tick();
        chk_out("mid_rst", 4'b0000, 16'h0000, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("post_rst", 4'b0001, 16'hFF00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
